ccff_chain_loader: RTL and testbench

//  Drives a configuration-chain tile (ccff_head in, ccff_tail out) from the bitstream side.

---
 rtl/ccff_chain_loader.sv | 155 +++++++++++++++
 tb/tb_ccff_chain_loader.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - serialises stream words onto a config chain behind a marker, checks the marker at ccff_tail
module ccff_chain_loader #(
    parameter int                WORD_W    = 16,
    parameter int                CHAIN_LEN = 64,
    parameter int                MARK_W    = 8,
    parameter logic [MARK_W-1:0] MARKER    = 8'hA5
) (
    input  logic              prog_clk,
    input  logic              pReset_n,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] bs_data,
    input  logic              bs_valid,
    output logic              bs_ready,
    output logic              config_enable,
    output logic              ccff_head,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              pass
);

    localparam int TOTAL   = MARK_W + CHAIN_LEN;
    localparam int N_WORDS = CHAIN_LEN / WORD_W;
    localparam int CW      = $clog2(TOTAL + 1);
    localparam int WW      = $clog2(N_WORDS + 1);
    localparam int BW      = $clog2(WORD_W + 1);

    localparam logic [CW-1:0] LAST_SHIFT = CW'(TOTAL - 1);
    localparam logic [CW-1:0] MARK_LAST  = CW'(MARK_W - 1);
    localparam logic [CW-1:0] WIN_LO     = CW'(CHAIN_LEN);
    localparam logic [CW-1:0] WIN_HI     = CW'(TOTAL);
    localparam logic [WW-1:0] WORDS_N    = WW'(N_WORDS);
    localparam logic [BW-1:0] BITS_FULL  = BW'(WORD_W);
    localparam logic [BW-1:0] BITS_ONE   = BW'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MARK,
        S_DATA,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_shift_cnt;
    logic [WW-1:0]      r_words;
    logic [WORD_W-1:0]  r_sr;
    logic [BW-1:0]      r_sr_bits;
    logic [MARK_W-1:0]  r_mark;
    logic [MARK_W-1:0]  r_chk;
    logic               r_err;
    logic               r_pass;

    logic w_in_mark;
    logic w_in_data;
    logic w_shift;
    logic w_ready;
    logic w_accept;
    logic w_check;
    logic w_mismatch;
    logic w_err_next;
    logic w_last;

    assign w_in_mark = (r_state == S_MARK);
    assign w_in_data = (r_state == S_DATA);
    assign w_shift   = w_in_mark | (w_in_data & (r_sr_bits != '0));

    // The first word is prefetched on the last marker shift so data follows the marker without a bubble.
    assign w_ready   = (r_words < WORDS_N) &
                       ((w_in_data & (r_sr_bits <= BITS_ONE)) |
                        (w_in_mark & (r_shift_cnt == MARK_LAST)));
    assign w_accept  = w_ready & bs_valid;

    // Marker bit k reaches the tail just before shift CHAIN_LEN+k.
    assign w_check    = w_shift & (r_shift_cnt >= WIN_LO) & (r_shift_cnt < WIN_HI);
    assign w_mismatch = w_check & (ccff_tail != r_chk[MARK_W-1]);
    assign w_err_next = r_err | w_mismatch;
    assign w_last     = w_shift & (r_shift_cnt == LAST_SHIFT);

    assign bs_ready      = w_ready;
    assign config_enable = w_shift;
    assign ccff_head     = w_in_mark ? r_mark[MARK_W-1] : (w_in_data & r_sr[WORD_W-1]);
    assign busy          = w_in_mark | w_in_data;
    assign done          = (r_state == S_DONE);
    assign pass          = r_pass;

    always_ff @(posedge prog_clk or negedge pReset_n) begin
        if (!pReset_n) begin
            r_state     <= S_IDLE;
            r_shift_cnt <= '0;
            r_words     <= '0;
            r_sr        <= '0;
            r_sr_bits   <= '0;
            r_mark      <= '0;
            r_chk       <= '0;
            r_err       <= 1'b0;
            r_pass      <= 1'b0;
        end else if (abort) begin
            r_state   <= S_IDLE;
            r_pass    <= 1'b0;
            r_sr      <= '0;
            r_sr_bits <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state     <= S_MARK;
                        r_shift_cnt <= '0;
                        r_words     <= '0;
                        r_sr        <= '0;
                        r_sr_bits   <= '0;
                        r_mark      <= MARKER;
                        r_chk       <= MARKER;
                        r_err       <= 1'b0;
                        r_pass      <= 1'b0;
                    end
                end
                S_MARK, S_DATA: begin
                    if (w_shift) begin
                        r_shift_cnt <= r_shift_cnt + CW'(1);
                        r_err       <= w_err_next;
                    end
                    if (w_check) begin
                        r_chk <= r_chk << 1;
                    end
                    if (w_in_mark) begin
                        r_mark <= r_mark << 1;
                        if (r_shift_cnt == MARK_LAST) begin
                            r_state <= S_DATA;
                        end
                    end
                    if (w_accept) begin
                        r_sr      <= bs_data;
                        r_sr_bits <= BITS_FULL;
                        r_words   <= r_words + WW'(1);
                    end else if (w_in_data & w_shift) begin
                        r_sr      <= r_sr << 1;
                        r_sr_bits <= r_sr_bits - BW'(1);
                    end
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_pass  <= ~w_err_next;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb/tb_ccff_chain_loader.sv - randomized self-checking bench for ccff_chain_loader driving a 64-FF chain model
module tb_ccff_chain_loader;

    localparam int          WORD_W    = 16;
    localparam int          CHAIN_LEN = 64;
    localparam int          MARK_W    = 8;
    localparam logic [7:0]  MARKER    = 8'hA5;
    localparam int          TOTAL     = MARK_W + CHAIN_LEN;

    logic              prog_clk = 1'b0;
    logic              pReset_n;
    logic              start;
    logic              abort;
    logic [WORD_W-1:0] bs_data;
    logic              bs_valid;
    logic              bs_ready;
    logic              config_enable;
    logic              ccff_head;
    logic              ccff_tail;
    logic              busy;
    logic              done;
    logic              pass;

    logic [CHAIN_LEN-1:0] chain;
    bit                   tail_zero;

    int n_checks;
    int n_fail;

    logic [TOTAL-1:0] obs_vec;
    int   obs_len;
    int   en_cnt;
    int   en_low_busy;
    int   done_cnt;
    int   done_cyc;
    int   last_en_cyc;
    int   ready_viol;
    logic pass_at_done;

    ccff_chain_loader #(
        .WORD_W(WORD_W),
        .CHAIN_LEN(CHAIN_LEN),
        .MARK_W(MARK_W),
        .MARKER(MARKER)
    ) dut (
        .prog_clk(prog_clk),
        .pReset_n(pReset_n),
        .start(start),
        .abort(abort),
        .bs_data(bs_data),
        .bs_valid(bs_valid),
        .bs_ready(bs_ready),
        .config_enable(config_enable),
        .ccff_head(ccff_head),
        .ccff_tail(ccff_tail),
        .busy(busy),
        .done(done),
        .pass(pass)
    );

    always #5 prog_clk = ~prog_clk;

    always @(posedge prog_clk) begin
        if (config_enable) chain <= {chain[CHAIN_LEN-2:0], ccff_head};
    end
    assign ccff_tail = tail_zero ? 1'b0 : chain[CHAIN_LEN-1];

    task automatic tick();
        @(posedge prog_clk);
        #1;
    endtask

    // Runs one load, stalling bs_valid for stall_len ready cycles before word stall_idx.
    task automatic do_load(input logic [15:0] w0, input logic [15:0] w1, input logic [15:0] w2,
                           input logic [15:0] w3, input int stall_idx, input int stall_len,
                           input bit extra, input bit start_in_mark);
        logic [15:0] w [4];
        int idx;
        int rem;
        int accepted;
        w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
        idx = 0; rem = stall_len; accepted = 0;
        obs_vec = '0; obs_len = 0; en_cnt = 0; en_low_busy = 0; done_cnt = 0;
        done_cyc = -10; last_en_cyc = -1; ready_viol = 0; pass_at_done = 1'bx;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (config_enable) begin
                obs_vec = {obs_vec[TOTAL-2:0], ccff_head};
                obs_len++;
                en_cnt++;
                last_en_cyc = cyc;
            end else if (busy) begin
                en_low_busy++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                pass_at_done = pass;
            end
            if (cyc == done_cyc + 1) break;
            if (accepted >= 4 && bs_ready) ready_viol++;
            start = (start_in_mark && cyc == 2);
            if (idx < 4) begin
                if (idx == stall_idx && rem > 0 && bs_ready) begin
                    bs_valid = 1'b0;
                    rem--;
                end else begin
                    bs_valid = 1'b1;
                    bs_data  = w[idx];
                end
                if (bs_valid && bs_ready) begin
                    accepted++;
                    idx++;
                end
            end else begin
                bs_valid = extra;
                bs_data  = 16'($urandom);
            end
            tick();
        end
        bs_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic test_reset();
        pReset_n = 1'b0;
        tick();
        n_checks++;
        if ({bs_ready, config_enable, ccff_head, busy, done, pass} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %b expected 000000",
                     {bs_ready, config_enable, ccff_head, busy, done, pass});
        end
        #3 pReset_n = 1'b1;
        tick();
        tick();
        n_checks++;
        if (busy !== 1'b0 || config_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: busy=%b config_enable=%b expected 0 0", busy, config_enable);
        end
    endtask

    task automatic test_basic();
        logic [TOTAL-1:0]     exp_bits;
        logic [CHAIN_LEN-1:0] exp_chain;
        exp_chain = {16'h1234, 16'hABCD, 16'h5555, 16'h0F0F};
        exp_bits  = {MARKER, exp_chain};
        do_load(16'h1234, 16'hABCD, 16'h5555, 16'h0F0F, -1, 0, 1'b0, 1'b0);
        n_checks++;
        if (en_cnt != TOTAL || en_low_busy != 0) begin
            n_fail++;
            $display("FAIL basic_enable_run: got %0d enabled, %0d gaps expected %0d, 0", en_cnt, en_low_busy, TOTAL);
        end
        n_checks++;
        if (obs_vec !== exp_bits) begin
            n_fail++;
            $display("FAIL basic_head_bits: got %h expected %h", obs_vec, exp_bits);
        end
        n_checks++;
        if (chain !== exp_chain) begin
            n_fail++;
            $display("FAIL basic_chain: got %h expected %h", chain, exp_chain);
        end
        n_checks++;
        if (done_cnt != 1 || done_cyc != last_en_cyc + 1) begin
            n_fail++;
            $display("FAIL basic_done: got %0d pulses at %0d expected 1 at %0d", done_cnt, done_cyc, last_en_cyc + 1);
        end
        n_checks++;
        if (pass_at_done !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_pass: got %b expected 1", pass_at_done);
        end
        tick();
        n_checks++;
        if (pass !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_pass_held: pass=%b busy=%b done=%b expected 1 0 0", pass, busy, done);
        end
    endtask

    task automatic test_stall(input int iters);
        logic [15:0] w [4];
        int sidx;
        int slen;
        bit smark;
        for (int it = 0; it < iters; it++) begin
            for (int k = 0; k < 4; k++) w[k] = 16'($urandom);
            if (it == 0) begin
                w[0] = 16'h1234; w[1] = 16'hABCD; w[2] = 16'h5555; w[3] = 16'h0F0F;
                sidx = 2; slen = 5; smark = 1'b0;
            end else begin
                sidx = $urandom_range(0, 3);
                slen = $urandom_range(1, 8);
                smark = 1'($urandom_range(0, 1));
            end
            do_load(w[0], w[1], w[2], w[3], sidx, slen, 1'b0, smark);
            n_checks++;
            if (en_cnt != TOTAL || en_low_busy != slen) begin
                n_fail++;
                $display("FAIL stall_enable[%0d]: got %0d enabled, %0d low expected %0d, %0d",
                         it, en_cnt, en_low_busy, TOTAL, slen);
            end
            n_checks++;
            if (obs_vec !== {MARKER, w[0], w[1], w[2], w[3]} || chain !== {w[0], w[1], w[2], w[3]}) begin
                n_fail++;
                $display("FAIL stall_data[%0d]: got chain %h expected %h", it, chain, {w[0], w[1], w[2], w[3]});
            end
            n_checks++;
            if (done_cnt != 1 || pass_at_done !== 1'b1) begin
                n_fail++;
                $display("FAIL stall_pass[%0d]: got %0d done, pass %b expected 1, 1", it, done_cnt, pass_at_done);
            end
        end
    endtask

    task automatic test_broken_chain();
        tail_zero = 1'b1;
        do_load(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), -1, 0, 1'b0, 1'b0);
        tail_zero = 1'b0;
        n_checks++;
        if (done_cnt != 1 || en_cnt != TOTAL) begin
            n_fail++;
            $display("FAIL broken_done: got %0d done after %0d shifts expected 1 after %0d", done_cnt, en_cnt, TOTAL);
        end
        n_checks++;
        if (pass_at_done !== 1'b0) begin
            n_fail++;
            $display("FAIL broken_pass: got %b expected 0", pass_at_done);
        end
    endtask

    task automatic test_abort();
        int shifts;
        int saw_done;
        logic [15:0] w [4];
        for (int k = 0; k < 4; k++) w[k] = 16'($urandom);
        shifts = 0;
        saw_done = 0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < 200 && shifts < MARK_W + 20; cyc++) begin
            if (config_enable) shifts++;
            bs_valid = 1'b1;
            bs_data  = 16'($urandom);
            tick();
        end
        bs_valid = 1'b0;
        abort = 1'b1;
        tick();
        abort = 1'b0;
        n_checks++;
        if ({busy, config_enable, bs_ready} !== 3'b000) begin
            n_fail++;
            $display("FAIL abort_outputs: got %b expected 000", {busy, config_enable, bs_ready});
        end
        for (int cyc = 0; cyc < 90; cyc++) begin
            if (done) saw_done++;
            tick();
        end
        n_checks++;
        if (saw_done != 0 || pass !== 1'b0) begin
            n_fail++;
            $display("FAIL abort_no_done: got %0d done, pass %b expected 0, 0", saw_done, pass);
        end
        do_load(w[0], w[1], w[2], w[3], -1, 0, 1'b0, 1'b0);
        n_checks++;
        if (chain !== {w[0], w[1], w[2], w[3]} || pass_at_done !== 1'b1) begin
            n_fail++;
            $display("FAIL abort_reload: got chain %h pass %b expected %h 1", chain, pass_at_done, {w[0], w[1], w[2], w[3]});
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] w [4];
        for (int k = 0; k < 4; k++) w[k] = 16'($urandom);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            bs_valid = 1'b1;
            bs_data  = 16'($urandom);
            tick();
        end
        bs_valid = 1'b1;
        #2 pReset_n = 1'b0;
        #1;
        n_checks++;
        if ({bs_ready, config_enable, ccff_head, busy, done, pass} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got %b expected 000000",
                     {bs_ready, config_enable, ccff_head, busy, done, pass});
        end
        tick();
        #3 pReset_n = 1'b1;
        for (int cyc = 0; cyc < 5; cyc++) tick();
        n_checks++;
        if (busy !== 1'b0 || config_enable !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_idle: busy=%b config_enable=%b expected 0 0", busy, config_enable);
        end
        bs_valid = 1'b0;
        do_load(w[0], w[1], w[2], w[3], -1, 0, 1'b0, 1'b0);
        n_checks++;
        if (chain !== {w[0], w[1], w[2], w[3]} || pass_at_done !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_reload: got chain %h pass %b expected %h 1", chain, pass_at_done, {w[0], w[1], w[2], w[3]});
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] w [4];
        for (int k = 0; k < 4; k++) w[k] = 16'($urandom);
        do_load(w[0], w[1], w[2], w[3], -1, 0, 1'b1, 1'b1);
        n_checks++;
        if (ready_viol != 0) begin
            n_fail++;
            $display("FAIL extra_word_ready: got %0d ready cycles expected 0", ready_viol);
        end
        n_checks++;
        if (en_cnt != TOTAL || obs_vec !== {MARKER, w[0], w[1], w[2], w[3]} || chain !== {w[0], w[1], w[2], w[3]}) begin
            n_fail++;
            $display("FAIL start_in_mark_data: got %0d shifts chain %h expected %0d %h",
                     en_cnt, chain, TOTAL, {w[0], w[1], w[2], w[3]});
        end
        n_checks++;
        if (done_cnt != 1 || pass_at_done !== 1'b1) begin
            n_fail++;
            $display("FAIL start_in_mark_pass: got %0d done pass %b expected 1 1", done_cnt, pass_at_done);
        end
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL start_abort_same: got busy %b expected 0", busy);
        end
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        start     = 1'b0;
        abort     = 1'b0;
        bs_valid  = 1'b0;
        bs_data   = '0;
        tail_zero = 1'b0;
        chain     = '0;
        test_reset();
        test_basic();
        test_stall(4);
        test_broken_chain();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
